rct_bit_packer: RTL and testbench
=================================

RCT_BIT_PACKER -- requirements
Module: rct_bit_packer

Interface
REQ-001 SHALL have parameter RCT_CUTOFF, default 21: consecutive identical raw bits that trip the Repetition Count Test (H=1, alpha=2^-20).
REQ-002 SHALL have parameter BLOCK_BITS, default 448: health-passed bits per block handed to the hash stage.
REQ-003 SHALL have port TRNG_Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port TRNG_Reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port Sample_In  input  1  raw entropy bit from the noise source.
REQ-006 SHALL have port Sample_Valid  input  1  Sample_In is valid this cycle; one bit consumed per high cycle.
REQ-007 SHALL have port Block_Data  output  BLOCK_BITS  packed block; first accepted bit in the MSB, last in the LSB.
REQ-008 SHALL have port Block_Valid  output  1  Block_Data holds a complete block.
REQ-009 SHALL have port Block_Ready  input  1  hash stage accepts the block.
REQ-010 SHALL have port failure  output  1  RCT failure active; bits are being discarded.
REQ-011 SHALL have port Fail_Count  output  8  count of RCT failure events; saturates at 255.

Function
REQ-012 SHALL run the RCT on every Sample_Valid cycle in every state: rep_count becomes 1 if this is the first sample after reset or Sample_In differs from last_bit, else rep_count+1, saturating at RCT_CUTOFF; last_bit <= Sample_In.
REQ-013 SHALL register failure = (updated rep_count == RCT_CUTOFF), so it rises on the edge that takes the RCT_CUTOFF-th identical bit and falls on the edge that takes the first differing bit.
REQ-014 SHALL increment Fail_Count once per 0->1 transition of failure, holding at 255.
REQ-015 SHALL implement a three-state FSM: FILL, FULL and FAIL.
REQ-016 FILL: a valid sample that does not trip the RCT SHALL shift into Block_Data at the LSB, with bit_cnt+1.
REQ-017 FILL: on the edge that stores bit BLOCK_BITS, the FSM SHALL go to FULL, bit_cnt <= 0, and Block_Valid <= 1.
REQ-018 FILL: a sample that trips the RCT SHALL be discarded, the partial block SHALL be discarded (bit_cnt <= 0), and the FSM SHALL go to FAIL.
REQ-019 FAIL: samples continuing the run SHALL be discarded.
REQ-020 FAIL: the first differing sample SHALL be stored as bit 0 of a new block (bit_cnt <= 1), and the FSM SHALL return to FILL.
REQ-021 FULL: Block_Valid and Block_Data SHALL hold stable until the handshake edge (Block_Valid & Block_Ready); samples SHALL be discarded, but the RCT still updates.
REQ-022 On the FULL handshake edge, Block_Valid SHALL go 0 next cycle; the FSM SHALL go to FAIL if failure is set after that edge, else to FILL; a sample arriving on the handshake cycle SHALL be discarded.
REQ-023 An RCT failure during FULL SHALL NOT invalidate the held block.
REQ-024 Block_Ready while not FULL SHALL be ignored.
REQ-025 bit_cnt SHALL be $clog2(BLOCK_BITS+1) bits wide; rep_count SHALL be $clog2(RCT_CUTOFF+1) bits wide; neither SHALL wrap.

Reset
REQ-026 TRNG_Reset high SHALL immediately force state FILL and clear Block_Data, Block_Valid, failure, Fail_Count, bit_cnt, rep_count, last_bit and the first-sample flag, regardless of clock.
REQ-027 Reset mid-fill or mid-FULL SHALL discard the partial or held block; Block_Valid SHALL drop with no handshake.
REQ-028 After reset release, the first valid sample SHALL be treated as a fresh run (rep_count=1).

Verification
REQ-029 Reset, then 448 valid samples alternating 1,0,... -> Block_Valid rises on the edge of sample 448; Block_Data = {224{2'b10}}; failure stays 0.
REQ-030 20 ones, then a 0, then alternating to fill -> no failure; block MSBs = twenty 1s then 0; Block_Valid after 448 samples.
REQ-031 10 alternating bits, then 21 ones -> failure=1 on the 21st-one edge; Fail_Count=1; bit_cnt=0; further ones discarded; next 0 -> failure=0, bit_cnt=1, FSM in FILL.
REQ-032 Block full with Block_Ready=0 for 50 cycles while samples stream -> Block_Data unchanged and Block_Valid held; Block_Ready=1 for one cycle -> Block_Valid=0 next cycle, refill starts with the next sample.
REQ-033 Assert TRNG_Reset asynchronously mid-cycle after 300 samples -> all outputs 0 without a clock edge; a fresh 448 samples are needed for Block_Valid.
REQ-034 256 separated 21-bit runs of identical bits -> Fail_Count saturates at 255 and never wraps to 0.

Source files
------------

// File: rtl/rct_bit_packer.sv
// Repetition Count Test health check feeding a block packer for a TRNG.
// Ports: TRNG_Clock/TRNG_Reset (async, active-high); Sample_In/Sample_Valid
// raw bit stream in; Block_Data/Block_Valid/Block_Ready packed block
// handshake out; failure (RCT tripped) and Fail_Count (saturating event count).
module rct_bit_packer #(
  parameter int RCT_CUTOFF = 21,
  parameter int BLOCK_BITS = 448
) (
  input  logic                  TRNG_Clock,
  input  logic                  TRNG_Reset,
  input  logic                  Sample_In,
  input  logic                  Sample_Valid,
  output logic [BLOCK_BITS-1:0] Block_Data,
  output logic                  Block_Valid,
  input  logic                  Block_Ready,
  output logic                  failure,
  output logic [7:0]            Fail_Count
);

  localparam int CW = $clog2(BLOCK_BITS + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(BLOCK_BITS - 1);
  localparam logic [RW-1:0] LP_CUT  = RW'(RCT_CUTOFF);
  localparam logic [RW-1:0] LP_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_FILL,
    S_FULL,
    S_FAIL
  } state_t;

  state_t                r_state;
  logic [BLOCK_BITS-1:0] r_data;
  logic                  r_valid;
  logic                  r_failure;
  logic [7:0]            r_fail_cnt;
  logic [CW-1:0]         r_bit_cnt;
  logic [RW-1:0]         r_rep;
  logic                  r_last;
  logic                  r_seen;

  logic                  w_new_run;
  logic [RW-1:0]         w_rep_next;
  logic                  w_trip;
  logic                  w_fail_next;
  logic [BLOCK_BITS-1:0] w_shift;

  // A run restarts on the first sample after reset or on a bit change;
  // otherwise the count grows and parks at the cutoff.
  assign w_new_run   = !r_seen || (Sample_In != r_last);
  assign w_rep_next  = w_new_run ? LP_ONE :
                       (r_rep == LP_CUT) ? LP_CUT : r_rep + LP_ONE;
  assign w_trip      = Sample_Valid && (w_rep_next == LP_CUT);
  // Failure as it will stand after this edge.
  assign w_fail_next = Sample_Valid ? (w_rep_next == LP_CUT) : r_failure;
  assign w_shift     = {r_data[BLOCK_BITS-2:0], Sample_In};

  assign Block_Data  = r_data;
  assign Block_Valid = r_valid;
  assign failure     = r_failure;
  assign Fail_Count  = r_fail_cnt;

  // Health test: runs on every valid sample regardless of FSM state.
  always_ff @(posedge TRNG_Clock or posedge TRNG_Reset) begin
    if (TRNG_Reset) begin
      r_rep      <= '0;
      r_last     <= 1'b0;
      r_seen     <= 1'b0;
      r_failure  <= 1'b0;
      r_fail_cnt <= '0;
    end else if (Sample_Valid) begin
      r_rep     <= w_rep_next;
      r_last    <= Sample_In;
      r_seen    <= 1'b1;
      r_failure <= w_fail_next;
      if (w_fail_next && !r_failure && (r_fail_cnt != 8'hFF))
        r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

  // Packer FSM.
  always_ff @(posedge TRNG_Clock or posedge TRNG_Reset) begin
    if (TRNG_Reset) begin
      r_state   <= S_FILL;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_trip) begin
            r_bit_cnt <= '0;
            r_state   <= S_FAIL;
          end else if (Sample_Valid) begin
            r_data <= w_shift;
            if (r_bit_cnt == LP_LAST) begin
              r_bit_cnt <= '0;
              r_valid   <= 1'b1;
              r_state   <= S_FULL;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_FAIL: begin
          // Only a bit that breaks the run can end the failure.
          if (Sample_Valid && !w_trip) begin
            r_data    <= w_shift;
            r_bit_cnt <= CW'(1);
            r_state   <= S_FILL;
          end
        end
        S_FULL: begin
          // Held block survives an RCT trip; samples here are dropped.
          if (Block_Ready) begin
            r_valid <= 1'b0;
            r_state <= w_fail_next ? S_FAIL : S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_rct_bit_packer.sv
// Directed self-checking bench for rct_bit_packer.
// Each scenario task drives samples and compares outputs inline.
module tb_rct_bit_packer;

  logic         clk;
  logic         rst;
  logic         s_in;
  logic         s_vld;
  logic [447:0] bdata;
  logic         bvalid;
  logic         bready;
  logic         fail;
  logic [7:0]   fcnt;

  int checks = 0;
  int errors = 0;
  logic fail_seen;
  logic [447:0] exp;
  logic [447:0] snap;

  rct_bit_packer #(.RCT_CUTOFF(21), .BLOCK_BITS(448)) dut (
    .TRNG_Clock  (clk),
    .TRNG_Reset  (rst),
    .Sample_In   (s_in),
    .Sample_Valid(s_vld),
    .Block_Data  (bdata),
    .Block_Valid (bvalid),
    .Block_Ready (bready),
    .failure     (fail),
    .Fail_Count  (fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic v, input logic b);
    s_vld = v;
    s_in  = b;
    @(posedge clk);
    #1;
    if (fail) fail_seen = 1'b1;
  endtask

  task automatic do_reset();
    s_vld  = 1'b0;
    s_in   = 1'b0;
    bready = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0);
    fail_seen = 1'b0;
  endtask

  task automatic release_block();
    bready = 1'b1;
    step(1'b0, 1'b0);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    s_vld  = 1'b0;
    s_in   = 1'b0;
    bready = 1'b0;
    rst    = 1'b1;
    #2;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", bvalid);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++; $display("FAIL reset_failure got %b exp 0", fail);
    end
    checks++;
    if (fcnt !== 8'd0) begin
      errors++; $display("FAIL reset_failcnt got %0d exp 0", fcnt);
    end
    checks++;
    if (bdata !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", bdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 448; i++) begin
      step(1'b1, (i % 2) == 0);
      if (i == 446) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL alt_early_valid got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL alt_valid got %b exp 1", bvalid);
    end
    checks++;
    if (bdata !== {224{2'b10}}) begin
      errors++; $display("FAIL alt_data got %h exp %h", bdata, {224{2'b10}});
    end
    checks++;
    if (fail_seen !== 1'b0) begin
      errors++; $display("FAIL alt_failure got %b exp 0", fail_seen);
    end
    // Handshake edge with a sample that must be dropped.
    bready = 1'b1;
    step(1'b1, 1'b1);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL alt_handshake got %b exp 0", bvalid);
    end
    for (int i = 0; i < 448; i++) begin
      step(1'b1, (i % 2) == 1);
      if (i == 446) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL refill_early got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1 || bdata !== {224{2'b01}}) begin
      errors++;
      $display("FAIL refill_data got %b/%h exp 1/%h", bvalid, bdata, {224{2'b01}});
    end
    release_block();
  endtask

  task automatic test_run20();
    logic b;
    do_reset();
    exp    = '0;
    bready = 1'b1;
    for (int i = 0; i < 448; i++) begin
      if (i == 100) bready = 1'b0;
      b = (i < 20) ? 1'b1 : (i == 20) ? 1'b0 : ((i % 2) == 1);
      exp = {exp[446:0], b};
      step(1'b1, b);
      if (i == 446) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL run20_early got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL run20_valid got %b exp 1", bvalid);
    end
    checks++;
    if (bdata[447:427] !== 21'h1FFFFE) begin
      errors++; $display("FAIL run20_msbs got %h exp 1ffffe", bdata[447:427]);
    end
    checks++;
    if (bdata !== exp) begin
      errors++; $display("FAIL run20_data got %h exp %h", bdata, exp);
    end
    checks++;
    if (fail_seen !== 1'b0) begin
      errors++; $display("FAIL run20_failure got %b exp 0", fail_seen);
    end
    release_block();
  endtask

  task automatic test_fail();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2) == 0);
    for (int j = 0; j < 21; j++) begin
      step(1'b1, 1'b1);
      if (j == 19) begin
        checks++;
        if (fail !== 1'b0) begin
          errors++; $display("FAIL rct_20th got %b exp 0", fail);
        end
      end
    end
    checks++;
    if (fail !== 1'b1 || fcnt !== 8'd1) begin
      errors++; $display("FAIL rct_trip got %b/%0d exp 1/1", fail, fcnt);
    end
    for (int j = 0; j < 5; j++) step(1'b1, 1'b1);
    checks++;
    if (fail !== 1'b1 || fcnt !== 8'd1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL rct_hold got %b/%0d/%b exp 1/1/0", fail, fcnt, bvalid);
    end
    step(1'b1, 1'b0);
    checks++;
    if (fail !== 1'b0) begin
      errors++; $display("FAIL rct_clear got %b exp 0", fail);
    end
    for (int i = 0; i < 447; i++) begin
      step(1'b1, (i % 2) == 0);
      if (i == 445) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL rct_early got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1 || bdata !== {224{2'b01}} || fcnt !== 8'd1) begin
      errors++;
      $display("FAIL rct_block got %b/%h/%0d exp 1/%h/1", bvalid, bdata, fcnt, {224{2'b01}});
    end
  endtask

  task automatic test_hold();
    int bad;
    bad  = 0;
    snap = bdata;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, (i < 25) ? ((i % 2) == 1) : 1'b1);
      if (bvalid !== 1'b1 || bdata !== snap) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
    end
    checks++;
    if (fail !== 1'b1 || fcnt !== 8'd2) begin
      errors++; $display("FAIL hold_rct got %b/%0d exp 1/2", fail, fcnt);
    end
    bready = 1'b1;
    step(1'b1, 1'b1);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || fail !== 1'b1) begin
      errors++; $display("FAIL hold_handshake got %b/%b exp 0/1", bvalid, fail);
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 447; i++) begin
      step(1'b1, (i % 2) == 0);
      if (i == 445) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL hold_refill_early got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1 || bdata !== {224{2'b01}}) begin
      errors++;
      $display("FAIL hold_refill got %b/%h exp 1/%h", bvalid, bdata, {224{2'b01}});
    end
    release_block();
  endtask

  task automatic test_async_reset();
    logic b;
    do_reset();
    for (int j = 0; j < 21; j++) step(1'b1, 1'b1);
    checks++;
    if (fcnt !== 8'd1) begin
      errors++; $display("FAIL ar_pre_cnt got %0d exp 1", fcnt);
    end
    for (int i = 0; i < 264; i++) step(1'b1, (i % 2) == 1);
    for (int j = 0; j < 15; j++) step(1'b1, 1'b1);
    checks++;
    if (bdata === '0) begin
      errors++; $display("FAIL ar_pre_data got %h exp nonzero", bdata);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bdata !== '0 || bvalid !== 1'b0 || fail !== 1'b0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL ar_clear got %h/%b/%b/%0d exp 0/0/0/0", bdata, bvalid, fail, fcnt);
    end
    rst = 1'b0;
    fail_seen = 1'b0;
    exp = '0;
    for (int i = 0; i < 448; i++) begin
      b = (i < 6) ? 1'b1 : (((i - 6) % 2) == 1);
      exp = {exp[446:0], b};
      step(1'b1, b);
      if (i == 446) begin
        checks++;
        if (bvalid !== 1'b0) begin
          errors++; $display("FAIL ar_early got %b exp 0", bvalid);
        end
      end
    end
    checks++;
    if (bvalid !== 1'b1 || bdata !== exp) begin
      errors++; $display("FAIL ar_block got %b/%h exp 1/%h", bvalid, bdata, exp);
    end
    checks++;
    if (fail_seen !== 1'b0) begin
      errors++; $display("FAIL ar_fresh_run got %b exp 0", fail_seen);
    end
    release_block();
  endtask

  task automatic test_saturate();
    int wraps;
    wraps = 0;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 21; j++) step(1'b1, (k % 2) == 0);
      if (fcnt === 8'd0) wraps++;
      if (k == 0) begin
        checks++;
        if (fcnt !== 8'd1 || fail !== 1'b1) begin
          errors++; $display("FAIL sat_first got %0d/%b exp 1/1", fcnt, fail);
        end
      end
      if (k == 254) begin
        checks++;
        if (fcnt !== 8'd255) begin
          errors++; $display("FAIL sat_255 got %0d exp 255", fcnt);
        end
      end
    end
    checks++;
    if (fcnt !== 8'd255 || fail !== 1'b1) begin
      errors++; $display("FAIL sat_hold got %0d/%b exp 255/1", fcnt, fail);
    end
    checks++;
    if (wraps !== 0) begin
      errors++; $display("FAIL sat_wrap got %0d exp 0", wraps);
    end
  endtask

  initial begin
    rst       = 1'b0;
    s_vld     = 1'b0;
    s_in      = 1'b0;
    bready    = 1'b0;
    fail_seen = 1'b0;
    exp       = '0;
    snap      = '0;
    test_reset();
    test_alternating();
    test_run20();
    test_fail();
    test_hold();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
